floo_aw_w_sync: RTL and testbench



---
 rtl/floo_aw_w_sync.sv | 194 +++++++++++++++++++
 tb/tb_floo_aw_w_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_aw_w_sync.sv
// AXI AW/W ordering stage for the chimney manager path.
// Holds W until its AW is accepted downstream and regenerates W last.

package floo_aw_w_sync_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [5:0]  atop;
        logic [1:0]  user;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic [1:0]  user;
    } w_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  user;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
        logic [1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [1:0]  user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_rsp_t;

endpackage

module floo_aw_w_sync
    import floo_aw_w_sync_pkg::*;
#(
    parameter int unsigned MaxOutstandingAw = 4,
    parameter type axi_req_t = floo_aw_w_sync_pkg::axi_req_t,
    parameter type axi_rsp_t = floo_aw_w_sync_pkg::axi_rsp_t,
    parameter int unsigned CntWidth = $clog2(MaxOutstandingAw + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  axi_req_t            axi_req_i,
    output axi_rsp_t            axi_rsp_o,
    output axi_req_t            axi_req_o,
    input  axi_rsp_t            axi_rsp_i,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                w_last_err_o
);

    localparam int unsigned PtrWidth = $clog2(MaxOutstandingAw);
    localparam logic [PtrWidth-1:0] PtrMax = PtrWidth'(MaxOutstandingAw - 1);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(MaxOutstandingAw);

    logic [7:0]          len_q [MaxOutstandingAw];
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [CntWidth-1:0] cnt_q;
    logic [7:0]          beat_q;
    logic                err_q;

    logic       full;
    logic       empty;
    logic [7:0] head_len;
    logic       is_last;
    logic       push;
    logic       w_hs;
    logic       pop;

    assign full     = (cnt_q == CntFull);
    assign empty    = (cnt_q == '0);
    assign head_len = len_q[rd_ptr_q];
    assign is_last  = (beat_q == head_len);

    // Gate AW on FIFO space and W on a pending accepted AW; force W last.
    always_comb begin
        axi_req_o          = axi_req_i;
        axi_req_o.aw_valid = axi_req_i.aw_valid & ~full & ~rst_i;
        axi_req_o.w_valid  = axi_req_i.w_valid & ~empty & ~rst_i;
        axi_req_o.ar_valid = axi_req_i.ar_valid & ~rst_i;
        axi_req_o.w.last   = is_last;

        axi_rsp_o          = axi_rsp_i;
        axi_rsp_o.aw_ready = axi_rsp_i.aw_ready & ~full & ~rst_i;
        axi_rsp_o.w_ready  = axi_rsp_i.w_ready & ~empty & ~rst_i;
        axi_rsp_o.b_valid  = axi_rsp_i.b_valid & ~rst_i;
        axi_rsp_o.r_valid  = axi_rsp_i.r_valid & ~rst_i;
    end

    assign push = axi_req_o.aw_valid & axi_rsp_i.aw_ready;
    assign w_hs = axi_req_o.w_valid & axi_rsp_i.w_ready;
    assign pop  = w_hs & is_last;

    // Store accepted burst lengths in order of AW acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(MaxOutstandingAw); i++) begin
                len_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (push) begin
            len_q[wr_ptr_q] <= axi_req_i.aw.len;
            wr_ptr_q <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrWidth'(1);
        end
    end

    // Advance the read side when the last beat of the head burst leaves.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
        end else if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + PtrWidth'(1);
        end
    end

    // Track occupancy; push and pop together leave it unchanged.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Count beats within the head burst, restarting at its last beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_q <= '0;
        end else if (w_hs) begin
            beat_q <= is_last ? 8'd0 : beat_q + 8'd1;
        end
    end

    // Latch any disagreement between incoming and expected W last.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (w_hs && (axi_req_i.w.last != is_last)) begin
            err_q <= 1'b1;
        end
    end

    assign outstanding_o = cnt_q;
    assign w_last_err_o  = err_q;

    // Structural invariants of the length FIFO.
    a_no_push_full : assert property (
        @(posedge clk_i) disable iff (rst_i) !(push && full)
    );
    a_no_pop_empty : assert property (
        @(posedge clk_i) disable iff (rst_i) !(pop && empty)
    );

endmodule

// File: tb/tb_floo_aw_w_sync.sv
// Directed bench for floo_aw_w_sync.
// Walks single, back-to-back, stall, backpressure, last-error and reset cases.

module tb_floo_aw_w_sync;
    import floo_aw_w_sync_pkg::*;

    logic     clk;
    logic     rst;
    axi_req_t req_i;
    axi_rsp_t rsp_o;
    axi_req_t req_o;
    axi_rsp_t rsp_i;
    logic [2:0] outstanding;
    logic       err;

    int total;
    int bad;

    floo_aw_w_sync #(
        .MaxOutstandingAw(4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .axi_req_i    (req_i),
        .axi_rsp_o    (rsp_o),
        .axi_req_o    (req_o),
        .axi_rsp_i    (rsp_i),
        .outstanding_o(outstanding),
        .w_last_err_o (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  lens [4];
        logic [12:1] exp_last;
        int  exp_out [13];

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req_i = '0;
        rsp_i = '0;
        rsp_i.aw_ready = 1'b1;
        rsp_i.w_ready  = 1'b1;
        rsp_i.ar_ready = 1'b1;

        // reset state with valids presented
        req_i.ar_valid = 1'b1;
        req_i.ar.addr  = 32'h1234_5678;
        req_i.aw_valid = 1'b1;
        rsp_i.r_valid  = 1'b1;
        rsp_i.r.data   = 32'hCAFE_0001;
        #3;
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ar_valid", 32'(req_o.ar_valid), 0);
        chk("rst_aw_valid", 32'(req_o.aw_valid), 0);
        chk("rst_r_valid", 32'(rsp_o.r_valid), 0);
        tick();
        tick();
        rst = 1'b0;
        req_i.aw_valid = 1'b0;
        #1;
        chk("ar_valid_pass", 32'(req_o.ar_valid), 1);
        chk("ar_addr_pass", req_o.ar.addr, 32'h1234_5678);
        chk("r_data_pass", rsp_o.r.data, 32'hCAFE_0001);
        chk("ar_ready_pass", 32'(rsp_o.ar_ready), 1);
        req_i.ar_valid = 1'b0;
        rsp_i.r_valid  = 1'b0;
        tick();

        // single write, W presented together with AW
        req_i.aw_valid = 1'b1;
        req_i.aw.len   = 8'd3;
        req_i.aw.atop  = 6'h21;
        req_i.w_valid  = 1'b1;
        req_i.w.last   = 1'b0;
        req_i.w.data   = 32'hA0;
        #1;
        chk("s_aw_valid", 32'(req_o.aw_valid), 1);
        chk("s_atop_pass", 32'(req_o.aw.atop), 32'h21);
        chk("s_w_held", 32'(req_o.w_valid), 0);
        chk("s_w_ready_held", 32'(rsp_o.w_ready), 0);
        chk("s_out0", 32'(outstanding), 0);
        tick();
        req_i.aw_valid = 1'b0;
        #1;
        chk("s_out1", 32'(outstanding), 1);
        for (int b = 0; b < 4; b++) begin
            req_i.w.data = 32'hA0 + 32'(b);
            req_i.w.last = (b == 3);
            #1;
            chk("s_w_valid", 32'(req_o.w_valid), 1);
            chk("s_w_last", 32'(req_o.w.last), (b == 3) ? 1 : 0);
            chk("s_w_data", req_o.w.data, 32'hA0 + 32'(b));
            tick();
        end
        req_i.w_valid = 1'b0;
        #1;
        chk("s_out_end", 32'(outstanding), 0);
        chk("s_err", 32'(err), 0);

        // back-to-back AWs len 0,1,0,7 fill the FIFO
        lens = '{0, 1, 0, 7};
        for (int i = 0; i < 4; i++) begin
            req_i.aw_valid = 1'b1;
            req_i.aw.len   = 8'(lens[i]);
            #1;
            chk("b_aw_ready", 32'(rsp_o.aw_ready), 1);
            tick();
        end
        // fifth AW presented while full
        req_i.aw.len = 8'd2;
        #1;
        chk("f_out4", 32'(outstanding), 4);
        chk("f_aw_ready0", 32'(rsp_o.aw_ready), 0);
        chk("f_aw_valid0", 32'(req_o.aw_valid), 0);

        exp_last = 12'b1000_0000_1101;
        exp_out  = '{0, 4, 3, 4, 3, 2, 2, 2, 2, 2, 2, 2, 2};
        req_i.w_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            req_i.w.last = exp_last[k];
            #1;
            chk("b_w_valid", 32'(req_o.w_valid), 1);
            chk("b_w_last", 32'(req_o.w.last), 32'(exp_last[k]));
            chk("b_outstanding", 32'(outstanding), 32'(exp_out[k]));
            if (k == 1) chk("f_aw_ready_b1", 32'(rsp_o.aw_ready), 0);
            if (k == 2) chk("f_aw_ready_b2", 32'(rsp_o.aw_ready), 1);
            tick();
            if (k == 2) req_i.aw_valid = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            req_i.w.last = (k == 2);
            #1;
            chk("f5_w_last", 32'(req_o.w.last), (k == 2) ? 1 : 0);
            chk("f5_outstanding", 32'(outstanding), 1);
            tick();
        end
        req_i.w_valid = 1'b0;
        #1;
        chk("b_out_end", 32'(outstanding), 0);
        chk("b_err", 32'(err), 0);

        // downstream AW backpressure for 10 cycles
        rsp_i.aw_ready = 1'b0;
        req_i.aw_valid = 1'b1;
        req_i.aw.len   = 8'd0;
        req_i.w_valid  = 1'b1;
        req_i.w.last   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("p_aw_valid", 32'(req_o.aw_valid), 1);
            chk("p_w_valid", 32'(req_o.w_valid), 0);
            chk("p_outstanding", 32'(outstanding), 0);
            tick();
        end
        rsp_i.aw_ready = 1'b1;
        #1;
        chk("p_aw_ready", 32'(rsp_o.aw_ready), 1);
        tick();
        req_i.aw_valid = 1'b0;
        #1;
        chk("p_w_valid_go", 32'(req_o.w_valid), 1);
        chk("p_w_last", 32'(req_o.w.last), 1);
        chk("p_out1", 32'(outstanding), 1);
        tick();
        req_i.w_valid = 1'b0;
        #1;
        chk("p_out0", 32'(outstanding), 0);

        // incoming last asserted one beat early
        req_i.aw_valid = 1'b1;
        req_i.aw.len   = 8'd1;
        tick();
        req_i.aw_valid = 1'b0;
        req_i.w_valid  = 1'b1;
        req_i.w.last   = 1'b1;
        #1;
        chk("m_last_b1", 32'(req_o.w.last), 0);
        chk("m_err_b1", 32'(err), 0);
        tick();
        chk("m_err_after", 32'(err), 1);
        chk("m_last_b2", 32'(req_o.w.last), 1);
        tick();
        req_i.w_valid = 1'b0;
        #1;
        chk("m_err_held", 32'(err), 1);
        chk("m_out0", 32'(outstanding), 0);

        // asynchronous reset in the middle of a len=7 burst
        req_i.aw_valid = 1'b1;
        req_i.aw.len   = 8'd7;
        tick();
        req_i.aw_valid = 1'b0;
        req_i.w_valid  = 1'b1;
        req_i.w.last   = 1'b0;
        tick();
        tick();
        chk("r_out_mid", 32'(outstanding), 1);
        req_i.aw_valid = 1'b1;
        req_i.aw.len   = 8'd5;
        req_i.ar_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("r_out_rst", 32'(outstanding), 0);
        chk("r_w_valid_rst", 32'(req_o.w_valid), 0);
        chk("r_aw_valid_rst", 32'(req_o.aw_valid), 0);
        chk("r_ar_valid_rst", 32'(req_o.ar_valid), 0);
        chk("r_err_rst", 32'(err), 0);
        tick();
        rst = 1'b0;
        req_i.ar_valid = 1'b0;
        req_i.aw.len   = 8'd0;
        req_i.w.last   = 1'b1;
        #1;
        chk("r_w_held", 32'(req_o.w_valid), 0);
        tick();
        req_i.aw_valid = 1'b0;
        #1;
        chk("r_w_valid", 32'(req_o.w_valid), 1);
        chk("r_w_last", 32'(req_o.w.last), 1);
        chk("r_out1", 32'(outstanding), 1);
        tick();
        req_i.w_valid = 1'b0;
        #1;
        chk("r_out0", 32'(outstanding), 0);
        chk("r_err0", 32'(err), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
